// File: rtl/cnn_pkg.sv
// Shared types and defaults for the activation-pass controller.
package cnn_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int ARR_INPUTS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } relu_state_t;
endpackage

// File: rtl/relu_stage_ctrl_relu_arr.sv
// reluArr: element-wise ReLU across one buffer row; en=1 passes the row unchanged.
module reluArr #(
   parameter int DATA_WIDTH = 16,
   parameter int ARR_INPUTS = 16
) (
   input  logic                             en,
   input  logic [DATA_WIDTH*ARR_INPUTS-1:0] in_data,
   output logic [DATA_WIDTH*ARR_INPUTS-1:0] out_data
);

   // Zero every non-positive element unless bypassed.
   always_comb begin
      out_data = in_data;
      if (!en) begin
         for (int i = 0; i < ARR_INPUTS; i++) begin
            if ($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]) <= 0)
               out_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end

endmodule

// File: rtl/relu_stage_ctrl.sv
// relu_stage_ctrl: one layer's activation pass, accumulator buffer -> reluArr -> activation buffer.
// Optional ReLU6-style clipping is built when RELU_CLIP_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for start, config not yet latched
//  RUN   | issuing reads, throttled by 2-entry output FIFO occupancy
//  DRAIN | all reads issued, emptying FIFO to the activation buffer
//  DONE  | one-cycle done pulse, back to IDLE
module relu_stage_ctrl
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int ARR_INPUTS = cnn_pkg::ARR_INPUTS,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [ADDR_WIDTH:0]              cfg_rows,
   input  logic [ADDR_WIDTH-1:0]            cfg_src_base,
   input  logic [ADDR_WIDTH-1:0]            cfg_dst_base,
   input  logic                             cfg_bypass,
`ifdef RELU_CLIP_EN
   input  logic [DATA_WIDTH-1:0]            clip_max,
`endif
   output logic                             busy,
   output logic                             done,
   output logic                             rd_en,
   output logic [ADDR_WIDTH-1:0]            rd_addr,
   input  logic [DATA_WIDTH*ARR_INPUTS-1:0] rd_data,
   output logic                             wr_valid,
   input  logic                             wr_ready,
   output logic [ADDR_WIDTH-1:0]            wr_addr,
   output logic [DATA_WIDTH*ARR_INPUTS-1:0] wr_data
);

   localparam int RW = DATA_WIDTH*ARR_INPUTS;

   relu_state_t           state;
   logic [ADDR_WIDTH:0]   rd_left;
   logic [ADDR_WIDTH:0]   wr_left;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic                  byp;
   logic                  inflight;
   logic [1:0]            fcnt;
   logic [RW-1:0]         fd0, fd1;
   logic [ADDR_WIDTH-1:0] fa0, fa1;
   logic [RW-1:0]         relu_out;
   logic [RW-1:0]         push_data;
   logic [2:0]            occ;
   logic                  pop;
   logic                  accept;

   assign accept   = (state == IDLE) && start;
   assign pop      = (fcnt != 2'd0) && wr_ready;
   // A slot freed by this cycle's pop is reusable, which keeps 1 row/cycle.
   assign occ      = {1'b0, fcnt} - {2'b0, pop} + {2'b0, inflight};
   assign rd_en    = (state == RUN) && (rd_left != '0) && (occ < 3'd2);
   assign rd_addr  = rd_ptr;
   assign wr_valid = (fcnt != 2'd0);
   assign wr_addr  = fa0;
   assign wr_data  = fd0;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   reluArr #(.DATA_WIDTH(DATA_WIDTH), .ARR_INPUTS(ARR_INPUTS)) u_relu (
      .en       (byp),
      .in_data  (rd_data),
      .out_data (relu_out)
   );

`ifdef RELU_CLIP_EN
   logic [DATA_WIDTH-1:0] clip_q;

   // Clip positive elements to clip_q; a non-positive clip_q disables clipping.
   always_comb begin
      push_data = relu_out;
      if (!byp && ($signed(clip_q) > 0)) begin
         for (int i = 0; i < ARR_INPUTS; i++) begin
            if ($signed(relu_out[i*DATA_WIDTH +: DATA_WIDTH]) > $signed(clip_q))
               push_data[i*DATA_WIDTH +: DATA_WIDTH] = clip_q;
         end
      end
   end

   // Clip threshold is part of the per-pass config.
   always_ff @(posedge clk) begin
      if (reset)       clip_q <= '0;
      else if (accept) clip_q <= clip_max;
   end
`else
   assign push_data = relu_out;
`endif

   // Pass sequencing: config latch, read issue and write-completion tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rd_left <= '0;
         wr_left <= '0;
         rd_ptr  <= '0;
         byp     <= 1'b0;
      end else begin
         if (pop) wr_left <= wr_left - 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  byp     <= cfg_bypass;
                  rd_ptr  <= cfg_src_base;
                  rd_left <= cfg_rows;
                  wr_left <= cfg_rows;
                  state   <= (cfg_rows == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (rd_en) begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  rd_left <= rd_left - 1'b1;
                  if (rd_left == 1) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && (wr_left == 1)) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-entry output FIFO; entry 0 is the head presented to the sink.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= 1'b0;
         fcnt     <= 2'd0;
         fd0      <= '0;
         fd1      <= '0;
         fa0      <= '0;
         fa1      <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= rd_en;
         if (accept)        wr_ptr <= cfg_dst_base;
         else if (inflight) wr_ptr <= wr_ptr + 1'b1;
         case ({inflight, pop})
            2'b10: begin
               if (fcnt == 2'd0) begin
                  fd0 <= push_data;
                  fa0 <= wr_ptr;
               end else begin
                  fd1 <= push_data;
                  fa1 <= wr_ptr;
               end
               fcnt <= fcnt + 2'd1;
            end
            2'b01: begin
               fd0  <= fd1;
               fa0  <= fa1;
               fcnt <= fcnt - 2'd1;
            end
            2'b11: begin
               if (fcnt == 2'd1) begin
                  fd0 <= push_data;
                  fa0 <= wr_ptr;
               end else begin
                  fd0 <= fd1;
                  fa0 <= fa1;
                  fd1 <= push_data;
                  fa1 <= wr_ptr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_relu_stage_ctrl.sv
// Scoreboard bench for relu_stage_ctrl: buffer model drives rd_data, reference rows are queued at start.
module tb_relu_stage_ctrl;

   localparam int DW = 16;
   localparam int AI = 16;
   localparam int AW = 10;
   localparam int RW = DW*AI;
   localparam int DEPTH = 1 << AW;
`ifdef RELU_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   cfg_rows = '0;
   logic [AW-1:0] cfg_src_base = '0;
   logic [AW-1:0] cfg_dst_base = '0;
   logic          cfg_bypass = 1'b0;
   logic [DW-1:0] clip_max = '0;
   logic          busy, done, rd_en, wr_valid;
   logic          wr_ready = 1'b1;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [RW-1:0] rd_data = '0;
   logic [RW-1:0] wr_data;

   relu_stage_ctrl #(.DATA_WIDTH(DW), .ARR_INPUTS(AI), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cfg_rows     (cfg_rows),
      .cfg_src_base (cfg_src_base),
      .cfg_dst_base (cfg_dst_base),
      .cfg_bypass   (cfg_bypass),
`ifdef RELU_CLIP_EN
      .clip_max     (clip_max),
`endif
      .busy         (busy),
      .done         (done),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [RW-1:0] data;
   } wr_t;

   logic [RW-1:0] mem [DEPTH];
   wr_t           sb [$];
   int            total = 0;
   int            bad = 0;
   int            mode = 0;
   int            pc, wr_cnt, rd_cnt, done_cnt, busy_cnt, first_wr_pc, done_pc, outstanding;
   logic [AW-1:0] exp_rd = '0;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [RW-1:0] prev_data;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int w = 0; w < RW/32; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   // Reference: negative -> 0, positive unchanged, optional clip, bypass keeps everything.
   function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] r, input bit byp, input int cm);
      logic [RW-1:0] o;
      logic [DW-1:0] e;
      int v;
      for (int i = 0; i < AI; i++) begin
         e = r[i*DW +: DW];
         v = $signed(e);
         if (!byp) begin
            if (v < 0) v = 0;
            if (CLIP && cm > 0 && v > cm) v = cm;
         end
         e = v[DW-1:0];
         o[i*DW +: DW] = e;
      end
      return o;
   endfunction

   // Sink ready pattern.
   always @(posedge clk) begin
      #1;
      case (mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = ~wr_ready;
         default: wr_ready = ($urandom_range(0, 1) == 1);
      endcase
   end

   // Accumulator buffer model: data valid only the cycle after rd_en, garbage otherwise.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      else       rd_data <= rand_row();
   end

   // Monitor: read address order, occupancy bound, write hold and scoreboard compare.
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         pc++;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_pc = pc;
         end
         if (rd_en) begin
            rd_cnt++;
            chk("rd_addr", rd_addr, exp_rd);
            exp_rd = exp_rd + 1'b1;
            outstanding++;
         end
         if (wr_valid) begin
            if (prev_stall) begin
               chk("hold_addr", wr_addr, prev_addr);
               chk_row("hold_data", wr_data, prev_data);
            end
            if (wr_ready) begin
               wr_cnt++;
               outstanding--;
               if (first_wr_pc < 0) first_wr_pc = pc;
               if (sb.size() == 0) begin
                  chk("unexpected_write", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("wr_addr", wr_addr, e.addr);
                  chk_row("wr_data", wr_data, e.data);
               end
            end
         end
         if (rd_en) chk("occupancy_le_2", (outstanding <= 2), 1);
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end
   end

   task automatic clear_counts();
      pc = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_wr_pc = -1; done_pc = -1; outstanding = 0;
   endtask

   task automatic do_start(input int rows, input int src, input int dst, input bit byp, input int cm);
      logic [AW-1:0] a;
      @(posedge clk); #1;
      cfg_rows = rows[AW:0];
      cfg_src_base = src[AW-1:0];
      cfg_dst_base = dst[AW-1:0];
      cfg_bypass = byp;
      clip_max = cm[DW-1:0];
      start = 1'b1;
      clear_counts();
      exp_rd = src[AW-1:0];
      for (int i = 0; i < rows; i++) begin
         a = (src + i) % DEPTH;
         sb.push_back('{addr: (dst + i) % DEPTH, data: ref_row(mem[a], byp, cm)});
      end
      @(posedge clk); #1;
      start = 1'b0;
      cfg_rows = $urandom_range(0, 2*DEPTH-1);
      cfg_src_base = $urandom_range(0, DEPTH-1);
      cfg_dst_base = $urandom_range(0, DEPTH-1);
      cfg_bypass = ~byp;
      clip_max = $urandom_range(0, 65535);
   endtask

   task automatic wait_done(input int rows, input bit timing);
      int n = 0;
      while (done_cnt == 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("wr_count", wr_cnt, rows);
      chk("rd_count", rd_cnt, rows);
      chk("sb_empty", sb.size(), 0);
      chk("busy_after", busy, 0);
      if (timing) begin
         if (rows == 0) begin
            chk("zero_done_pc", done_pc, 2);
            chk("zero_busy", busy_cnt, 1);
         end else begin
            chk("first_wr_latency", first_wr_pc, 4);
            chk("done_pc", done_pc, rows + 4);
            chk("busy_cycles", busy_cnt, rows + 3);
         end
      end
   endtask

   task automatic run_pass(input int rows, input int src, input int dst, input bit byp,
                           input int md, input int cm);
      mode = md;
      do_start(rows, src, dst, byp, cm);
      wait_done(rows, md == 0);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_wr_valid"}, wr_valid, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data_zero"}, (wr_data == '0), 1);
   endtask

   initial begin
      int n;
      logic [RW-1:0] r;
      logic [DW-1:0] pat;
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_row();
      clear_counts();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle("reset");

      // 1: plain ReLU, full rate
      run_pass(4, 'h010, 'h200, 1'b0, 0, 0);

      // 2: bypass with {-5,0,7} elements
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < AI; i++) begin
            pat = ((i % 3) == 0) ? -16'sd5 : (((i % 3) == 1) ? 16'd0 : 16'd7);
            r[i*DW +: DW] = pat;
         end
         mem['h020 + k] = r;
      end
      run_pass(3, 'h020, 'h210, 1'b1, 0, 0);

      // 3: toggling ready, plus a start while busy that must be ignored
      mode = 1;
      do_start(8, 'h040, 'h300, 1'b0, 100);
      repeat (4) @(posedge clk);
      #1;
      cfg_rows = 2; cfg_dst_base = 'h3F0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(8, 1'b0);

      // 4: source and destination wrap
      run_pass(4, DEPTH-2, DEPTH-1, 1'b0, 0, 0);

      // 5: zero rows
      run_pass(0, 'h100, 'h100, 1'b0, 0, 0);

      // 6: reset mid-pass, then a fresh pass
      mode = 0;
      do_start(6, 'h080, 'h180, 1'b0, 0);
      n = 0;
      while (wr_cnt < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("abort_wait_timeout", 0, 1);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      clear_counts();
      @(negedge clk);
      check_idle("abort");
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_no_write", wr_cnt, 0);
      run_pass(3, 'h0A0, 'h1C0, 1'b0, 0, 0);

      // Randomized passes
      for (int k = 0; k < 8; k++) begin
         run_pass($urandom_range(1, 24), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 2),
                  $urandom_range(0, 1) ? $urandom_range(1, 20000) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
